// File: rtl/banco_fifos_if.sv
// rtl/banco_fifos_if.sv - arbiter and port-side signal bundle for the banco_fifos lane bank
// The error member exists only when BANCO_FIFOS_ERR_EN is defined.
interface banco_fifos_if #(
  parameter int WIDTH = 12
);
  logic [3:0]         in_push;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_full;
  logic [3:0]         pop;
  logic [3:0]         push;
  logic [3:0]         empty;
  logic [3:0]         almost_full;
  logic [WIDTH-1:0]   fifo_out;
  logic [3:0]         out_pop;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_empty;
`ifdef BANCO_FIFOS_ERR_EN
  logic               error;

  modport master (
    output in_push, in_data, pop, push, out_pop,
    input  in_full, empty, almost_full, fifo_out, out_data, out_empty, error
  );

  modport slave (
    input  in_push, in_data, pop, push, out_pop,
    output in_full, empty, almost_full, fifo_out, out_data, out_empty, error
  );
`else
  modport master (
    output in_push, in_data, pop, push, out_pop,
    input  in_full, empty, almost_full, fifo_out, out_data, out_empty
  );

  modport slave (
    input  in_push, in_data, pop, push, out_pop,
    output in_full, empty, almost_full, fifo_out, out_data, out_empty
  );
`endif
endinterface

// File: rtl/banco_fifos.sv
// rtl/banco_fifos.sv - four ingress and four egress circular FIFOs serving the switch arbiter
// Defining BANCO_FIFOS_ERR_EN adds a sticky error flag for dropped or illegal requests.
module banco_fifos #(
  parameter int WIDTH     = 12,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3
) (
  input  logic          clk,
  input  logic          reset,
  banco_fifos_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0][DEPTH-1:0][WIDTH-1:0] in_mem;
  logic [3:0][DEPTH-1:0][WIDTH-1:0] eg_mem;
  logic [3:0][AW-1:0]               in_rp, in_wp, eg_rp, eg_wp;
  logic [3:0][CW-1:0]               in_cnt, eg_cnt;
  logic [WIDTH-1:0]                 fifo_out_q;
  logic [WIDTH-1:0]                 pop_head;

  logic       pop_onehot, push_onehot;
  logic [3:0] in_is_full, eg_is_full;
  logic [3:0] pop_acc, in_wr, out_pop_acc, push_acc;

  // Acceptance decode; a full FIFO still takes a write when its own read frees a slot.
  always_comb begin
    pop_onehot  = (bus.pop != 4'd0) && ((bus.pop & (bus.pop - 4'd1)) == 4'd0);
    push_onehot = (bus.push != 4'd0) && ((bus.push & (bus.push - 4'd1)) == 4'd0);
    pop_head    = '0;
    in_is_full  = '0;
    eg_is_full  = '0;
    pop_acc     = '0;
    in_wr       = '0;
    out_pop_acc = '0;
    push_acc    = '0;
    for (int i = 0; i < 4; i++) begin
      in_is_full[i]  = (in_cnt[i] == CW'(DEPTH));
      eg_is_full[i]  = (eg_cnt[i] == CW'(DEPTH));
      pop_acc[i]     = pop_onehot && bus.pop[i] && (in_cnt[i] != '0);
      in_wr[i]       = bus.in_push[i] && (!in_is_full[i] || pop_acc[i]);
      out_pop_acc[i] = bus.out_pop[i] && (eg_cnt[i] != '0);
      push_acc[i]    = push_onehot && bus.push[i] && (!eg_is_full[i] || out_pop_acc[i]);
      if (pop_acc[i]) begin
        pop_head = in_mem[i][in_rp[i]];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_mem     <= '0;
      in_rp      <= '0;
      in_wp      <= '0;
      in_cnt     <= '0;
      fifo_out_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (in_wr[i]) begin
          in_mem[i][in_wp[i]] <= bus.in_data[i*WIDTH +: WIDTH];
          in_wp[i]            <= in_wp[i] + AW'(1);
        end
        if (pop_acc[i]) begin
          in_rp[i] <= in_rp[i] + AW'(1);
        end
        in_cnt[i] <= in_cnt[i] + CW'(in_wr[i]) - CW'(pop_acc[i]);
      end
      if (|pop_acc) begin
        fifo_out_q <= pop_head;
      end
    end
  end

  // Egress writes take the pre-edge fifo_out, so a pop and a push in one cycle stay pipelined.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eg_mem <= '0;
      eg_rp  <= '0;
      eg_wp  <= '0;
      eg_cnt <= '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (push_acc[j]) begin
          eg_mem[j][eg_wp[j]] <= fifo_out_q;
          eg_wp[j]            <= eg_wp[j] + AW'(1);
        end
        if (out_pop_acc[j]) begin
          eg_rp[j] <= eg_rp[j] + AW'(1);
        end
        eg_cnt[j] <= eg_cnt[j] + CW'(push_acc[j]) - CW'(out_pop_acc[j]);
      end
    end
  end

  assign bus.fifo_out = fifo_out_q;

  for (genvar g = 0; g < 4; g++) begin : g_status
    assign bus.empty[g]                    = (in_cnt[g] == '0);
    assign bus.in_full[g]                  = in_is_full[g];
    assign bus.out_empty[g]                = (eg_cnt[g] == '0);
    assign bus.almost_full[g]              = (eg_cnt[g] >= CW'(AF_THRESH));
    assign bus.out_data[g*WIDTH +: WIDTH]  = eg_mem[g][eg_rp[g]];
  end

`ifdef BANCO_FIFOS_ERR_EN
  logic err_q;
  logic err_evt;

  always_comb begin
    err_evt = ((bus.pop != 4'd0) && !pop_onehot) || ((bus.push != 4'd0) && !push_onehot);
    for (int i = 0; i < 4; i++) begin
      if ((bus.in_push[i] && !in_wr[i]) ||
          (pop_onehot && bus.pop[i] && (in_cnt[i] == '0)) ||
          (push_onehot && bus.push[i] && !push_acc[i]) ||
          (bus.out_pop[i] && (eg_cnt[i] == '0))) begin
        err_evt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_evt) begin
      err_q <= 1'b1;
    end
  end

  assign bus.error = err_q;
`endif

endmodule

// File: tb/tb_banco_fifos.sv
// tb/tb_banco_fifos.sv - randomized and directed bench for banco_fifos against a queue model
module tb_banco_fifos;
  localparam int W = 12;
  localparam int D = 4;
  localparam int AF = 3;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  bit   check_en;

  banco_fifos_if #(.WIDTH(W)) bus ();

  banco_fifos #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] inq  [4][$];
  logic [W-1:0] outq [4][$];
  logic [W-1:0] m_fo;
  logic [W-1:0] nfo;
  bit           m_err;
  bit           pop_ok, push_ok;
  logic [3:0]   pa;
  logic [3:0]   e_empty, e_full, e_oempty, e_af;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: each FIFO is a queue; ingress reads are taken before writes so an empty lane never bypasses.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        inq[i].delete();
        outq[i].delete();
      end
      m_fo  = '0;
      m_err = 1'b0;
    end else begin
      pop_ok  = ($countones(bus.pop) == 1);
      push_ok = ($countones(bus.push) == 1);
      if (bus.pop != 4'd0 && !pop_ok) m_err = 1'b1;
      if (bus.push != 4'd0 && !push_ok) m_err = 1'b1;
      nfo = m_fo;
      for (int i = 0; i < 4; i++) begin
        pa[i] = pop_ok && bus.pop[i] && (inq[i].size() > 0);
        if (pop_ok && bus.pop[i] && inq[i].size() == 0) m_err = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (pa[i]) nfo = inq[i].pop_front();
        if (bus.in_push[i]) begin
          if (inq[i].size() < D) inq[i].push_back(bus.in_data[i*W +: W]);
          else m_err = 1'b1;
        end
      end
      for (int j = 0; j < 4; j++) begin
        if (bus.out_pop[j]) begin
          if (outq[j].size() > 0) void'(outq[j].pop_front());
          else m_err = 1'b1;
        end
        if (push_ok && bus.push[j]) begin
          if (outq[j].size() < D) outq[j].push_back(m_fo);
          else m_err = 1'b1;
        end
      end
      m_fo = nfo;
    end
  end

  always @(negedge clk) begin
    if (check_en && !reset) begin
      for (int i = 0; i < 4; i++) begin
        e_empty[i]  = (inq[i].size() == 0);
        e_full[i]   = (inq[i].size() == D);
        e_oempty[i] = (outq[i].size() == 0);
        e_af[i]     = (outq[i].size() >= AF);
      end
      chk("empty", bus.empty, e_empty);
      chk("in_full", bus.in_full, e_full);
      chk("out_empty", bus.out_empty, e_oempty);
      chk("almost_full", bus.almost_full, e_af);
      chk("fifo_out", bus.fifo_out, m_fo);
      for (int j = 0; j < 4; j++) begin
        if (outq[j].size() > 0) chk($sformatf("out_data%0d", j), bus.out_data[j*W +: W], outq[j][0]);
      end
`ifdef BANCO_FIFOS_ERR_EN
      chk("error", bus.error, m_err);
`endif
    end
  end

  task automatic idle();
    bus.in_push = '0;
    bus.in_data = '0;
    bus.pop     = '0;
    bus.push    = '0;
    bus.out_pop = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, bus.empty, 4'b1111);
    chk({tag, "_out_empty"}, bus.out_empty, 4'b1111);
    chk({tag, "_almost_full"}, bus.almost_full, 4'b0000);
    chk({tag, "_in_full"}, bus.in_full, 4'b0000);
    chk({tag, "_fifo_out"}, bus.fifo_out, 12'h000);
    chk({tag, "_out_data"}, bus.out_data, 48'h0);
`ifdef BANCO_FIFOS_ERR_EN
    chk({tag, "_error"}, bus.error, 1'b0);
`endif
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    check_en = 1'b0;
    reset    = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset    = 1'b0;
    check_en = 1'b1;

    bus.in_push = 4'b0001;
    bus.in_data[11:0] = 12'h2A5;
    step(); idle();
    chk("t1_empty", bus.empty, 4'b1110);
    bus.pop = 4'b0001;
    step(); idle();
    chk("t1_fifo_out", bus.fifo_out, 12'h2A5);
    chk("t1_empty_after_pop", bus.empty, 4'b1111);

    bus.in_push = 4'b0001;
    bus.in_data[11:0] = 12'h1C3;
    step(); idle();
    bus.pop = 4'b0001;
    step(); idle();
    bus.push = 4'b0010;
    step(); idle();
    chk("t2_out_empty1", bus.out_empty[1], 1'b0);
    chk("t2_out_data1", bus.out_data[23:12], 12'h1C3);
    bus.out_pop = 4'b0010;
    step(); idle();
    chk("t2_drained", bus.out_empty, 4'b1111);
`ifdef BANCO_FIFOS_ERR_EN
    chk("t2_no_error", bus.error, 1'b0);
`endif

    for (int k = 0; k < 5; k++) begin
      bus.in_push = 4'b0001;
      bus.in_data[11:0] = 12'h3A0 + 12'(k);
      step(); idle();
      bus.pop = 4'b0001;
      step(); idle();
      bus.push = 4'b1000;
      step(); idle();
      if (k == 1) chk("t3_af_below", bus.almost_full, 4'b0000);
      if (k == 2) chk("t3_af_three", bus.almost_full, 4'b1000);
    end
    chk("t3_af_full", bus.almost_full, 4'b1000);
`ifdef BANCO_FIFOS_ERR_EN
    chk("t3_error", bus.error, 1'b1);
`endif
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_read%0d", k), bus.out_data[47:36], 12'h3A0 + 12'(k));
      bus.out_pop = 4'b1000;
      step(); idle();
    end
    chk("t3_empty_after_reads", bus.out_empty[3], 1'b1);

    for (int k = 0; k <= 10; k++) begin
      bus.in_push = (k < 10) ? 4'b0100 : 4'b0000;
      bus.in_data[35:24] = 12'(k);
      bus.pop = (k > 0) ? 4'b0100 : 4'b0000;
      step(); idle();
      if (k > 0) chk($sformatf("t4_wrap%0d", k - 1), bus.fifo_out, 12'(k - 1));
      chk($sformatf("t4_lane2_empty%0d", k), bus.empty[2], (k == 10) ? 1'b1 : 1'b0);
    end

    bus.in_push = 4'b0101;
    bus.in_data[11:0]  = 12'h011;
    bus.in_data[35:24] = 12'h022;
    step(); idle();
    bus.pop = 4'b0101;
    step(); idle();
    chk("t5_multi_pop_hold", bus.fifo_out, 12'h009);
    chk("t5_multi_pop_empty", bus.empty, 4'b1010);
    bus.pop = 4'b0010;
    bus.in_push = 4'b0010;
    bus.in_data[23:12] = 12'h033;
    step(); idle();
    chk("t5_empty_pop_hold", bus.fifo_out, 12'h009);
    chk("t5_no_bypass", bus.empty, 4'b1000);

    bus.push = 4'b0001;
    step(); idle();
    chk("t6_pre_out_empty", bus.out_empty, 4'b1110);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async");
    @(negedge clk);
    reset = 1'b0;
    bus.in_push = 4'b0001;
    bus.in_data[11:0] = 12'h0AB;
    step(); idle();
    chk("t6_first_push", bus.empty, 4'b1110);

    for (int n = 0; n < 1500; n++) begin
      bus.in_push = 4'($urandom);
      bus.in_data = {16'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) != 0) bus.pop = 4'b0001 << $urandom_range(0, 3);
      else bus.pop = 4'($urandom);
      if ($urandom_range(0, 1) == 0) bus.push = 4'b0001 << bus.fifo_out[9:8];
      else if ($urandom_range(0, 3) == 0) bus.push = 4'($urandom);
      else bus.push = 4'b0000;
      bus.out_pop = 4'($urandom) & 4'($urandom);
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/banco_fifos.md
# banco_fifos

Four-lane FIFO bank forming the responder side of the arbiter interface. It holds four ingress FIFOs, which the arbiter pops, and four egress FIFOs, which the arbiter pushes. It drives `empty`, `almost_full` and `fifo_out` back to the arbiter. It replaces the behavioural FIFO stimulus used in arbiter benches and sits between the input ports, the arbiter and the output ports of the switch.

## Interface
- `WIDTH`, 12: word width; bits [9:8] carry the destination lane; must be ≥10.
- `DEPTH`, 4: entries per FIFO; power of two.
- `AF_THRESH`, 3: an egress FIFO asserts almost_full when its occupancy ≥ AF_THRESH.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `in_push` input 4: per-lane write strobe into ingress FIFO i.
- `in_data` input 4*WIDTH: lane i word at [i*WIDTH +: WIDTH].
- `pop` input 4: from the arbiter; one-hot pop of ingress FIFO i.
- `push` input 4: from the arbiter; one-hot push of `fifo_out` into egress FIFO j.
- `empty` output 4: ingress FIFO i holds 0 words.
- `almost_full` output 4: egress FIFO j occupancy ≥ AF_THRESH.
- `fifo_out` output WIDTH: registered word from the last accepted pop.
- `out_pop` input 4: downstream read strobe of egress FIFO j.
- `out_data` output 4*WIDTH: head of egress FIFO j, first-word fall-through.
- `out_empty` output 4: egress FIFO j holds 0 words.
- `in_full` output 4: ingress FIFO i holds DEPTH words.

## Operation
- Each of the 8 FIFOs is a circular buffer with a read pointer, a write pointer (log2 DEPTH bits, natural wrap) and a count (log2 DEPTH + 1 bits).
- **Ingress write:** accepted when `in_push[i]` is high and the FIFO is not full, or when it is full and a pop of the same lane is accepted in that cycle. Otherwise the word is dropped.
- **Ingress pop:** accepted only when `pop` is one-hot, `pop[i]` is high and count_i > 0.
  - On acceptance, `fifo_out` loads the head of FIFO i, and the read pointer and count update.
  - A non-one-hot `pop`, including 4'b0000, is ignored and `fifo_out` holds.
  - A pop on an empty FIFO is ignored, including when a push to that FIFO occurs in the same cycle (no bypass).
- **Egress push:** accepted when `push` is one-hot and FIFO j is not full, or when it is full and `out_pop[j]` is accepted in the same cycle. The written word is the current `fifo_out` register value. A non-one-hot `push` is ignored.
- **Egress pop:** `out_pop[j]` with count_j > 0 advances the FIFO. `out_pop` on an empty FIFO is ignored.
- **Simultaneous push and pop** on the same nonempty FIFO: the count is unchanged and both pointers advance.
- **Status flags:** `empty`, `out_empty`, `in_full` and `almost_full` are decoded combinationally from the registered counts.
- **Reset values:**
  - All pointers and counts = 0.
  - Memories and `fifo_out` = 0, so `out_data` = 0.
  - `empty` = 4'b1111, `out_empty` = 4'b1111.
  - `almost_full` = 4'b0000, `in_full` = 4'b0000.

## Timing
- `in_push` at edge t: `empty[i]` falls after edge t.
- `pop[i]` accepted at edge t: the word appears on `fifo_out` after edge t, and `empty[i]` updates after edge t.
- The arbiter asserts `push[j]` in cycle t+1 with j = `fifo_out[9:8]`. The word is written at edge t+1, and `out_empty[j]` and `almost_full[j]` update after edge t+1.
- Ingress-to-`out_data` latency is 3 edges: in_push, pop, push.
- Reset asserted mid-operation clears everything immediately, regardless of the clock. The first push is accepted at the first edge after reset deasserts.

## Configuration
- `BANCO_FIFOS_ERR_EN` defined:
  - Adds an output `error`, 1 bit, sticky and registered.
  - It is set at the edge of any dropped ingress write, empty pop, non-one-hot nonzero `pop`/`push`, egress push on a full FIFO, or `out_pop` on an empty FIFO.
  - It is cleared only by `reset`.
- Undefined: no `error` port; illegal events are silently ignored as described above.

## Test plan
- Reset, then `in_push` = 4'b0001 with `in_data[11:0]` = 12'h2A5 → `empty` = 4'b1110. Then `pop` = 4'b0001 → `fifo_out` = 12'h2A5 and `empty` = 4'b1111 one edge later.
- Full path: the ingress word 12'h1C3 (dest 2'b01) is popped, then `push` = 4'b0010 → `out_empty[1]` = 0 and `out_data[23:12]` = 12'h1C3 three edges after `in_push`.
- Push 3 words into egress lane 3 → `almost_full` = 4'b1000. A 4th push is accepted; a 5th push is dropped (`error` = 1 with `BANCO_FIFOS_ERR_EN`). Then 4 `out_pop` reads return the words in order.
- Wrap-around: 10 push/pop pairs on ingress lane 2 with values 0..9 → `fifo_out` sequence is 0..9 and the count never exceeds 1.
- `pop` = 4'b0101 with both lanes nonempty → `fifo_out` holds and both counts are unchanged. `pop` on an empty lane → no change.
- Assert `reset` asynchronously between edges with 3 FIFOs nonempty → all outputs take their reset values before the next edge.
